// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, special instruction words,
// reset vector, drain length, fetch FSM encoding and a branch-target helper.
package mips_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DRAIN_CNT_W = 2;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [XLEN-1:0] FIN_WORD     = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_DRAIN = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  // PC-relative branch target: (pc+4) + sign-extended word offset, wrapping.
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc_plus4,
                                                    input logic [15:0]     imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_predecode.sv
// Static predecode of the fetched word plus the 1-bit direction predictor.
// Ports: clk_i/rst_ni clock and async active-low reset; imem_data_i fetched
// word; ifpc_i fetch PC; pred_upd_i/dbps_i predictor update strobe and new
// direction; next_pc_c_o predicted next fetch PC (combinational).
module branch_predecode
  import mips_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] imem_data_i,
  input  logic [XLEN-1:0] ifpc_i,
  input  logic            pred_upd_i,
  input  logic            dbps_i,
  output logic [XLEN-1:0] next_pc_c_o
);

  logic            pred_q, pred_d;
  logic [5:0]      opcode;
  logic            is_branch;
  logic [XLEN-1:0] ifpc_plus4;
  logic            unused_bits;

  // Predictor mirrors the controller's resolved direction.
  always_comb begin
    pred_d = pred_q;
    if (pred_upd_i) pred_d = dbps_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pred_q <= 1'b0;
    else         pred_q <= pred_d;
  end

  assign opcode      = imem_data_i[31:26];
  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign ifpc_plus4  = ifpc_i + 32'd4;
  assign unused_bits = ^imem_data_i[25:16];

  // Predicted-taken conditional branches redirect fetch immediately.
  always_comb begin
    next_pc_c_o = ifpc_plus4;
    if (is_branch && pred_q) next_pc_c_o = branch_target(ifpc_plus4, imem_data_i[15:0]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, IF/ID register, redirect/stall/SMC
// handling and a RUN -> DRAIN -> HALT shutdown sequence.
// Ports: CLK/RESETN clock and async active-low reset; IMEM_DATA word at IFPC;
// WPCIR stall; BRANCH/JUMP/JR/DBPS redirect controls; SMC/SMC2 self-modifying
// code hits in ID/IF; FIN halt decoded in ID; JR_RS jump-register target;
// IFPC/IDPC/IDIR fetch PC, ID PC and IF/ID word; HALTED pipeline drained.
module fetch_unit
  import mips_pkg::*;
(
  input  logic            CLK,
  input  logic            RESETN,
  input  logic [XLEN-1:0] IMEM_DATA,
  input  logic            WPCIR,
  input  logic            BRANCH,
  input  logic            JUMP,
  input  logic            JR,
  input  logic            DBPS,
  input  logic            SMC,
  input  logic            SMC2,
  input  logic            FIN,
  input  logic [XLEN-1:0] JR_RS,
  output logic [XLEN-1:0] IFPC,
  output logic [XLEN-1:0] IDPC,
  output logic [XLEN-1:0] IDIR,
  output logic            HALTED
);

  fetch_state_e           state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [XLEN-1:0]        ifpc_q, ifpc_d, idpc_q, idpc_d, idir_q, idir_d;
  logic                   halted_q;
  logic                   pred_upd;
  logic [XLEN-1:0]        pred_npc, idpc_plus4, redirect_tgt;

  branch_predecode u_predecode (
    .clk_i       (CLK),
    .rst_ni      (RESETN),
    .imem_data_i (IMEM_DATA),
    .ifpc_i      (ifpc_q),
    .pred_upd_i  (pred_upd),
    .dbps_i      (DBPS),
    .next_pc_c_o (pred_npc)
  );

  // Redirect target for the instruction currently in ID.
  assign idpc_plus4 = idpc_q + 32'd4;

  always_comb begin
    if (JUMP)      redirect_tgt = {idpc_plus4[31:28], idir_q[25:0], 2'b00};
    else if (JR)   redirect_tgt = JR_RS;
    else if (DBPS) redirect_tgt = branch_target(idpc_plus4, idir_q[15:0]);
    else           redirect_tgt = idpc_plus4;
  end

  // Next-state: halt sequencing > SMC > stall > redirect > predicted/sequential.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    ifpc_d      = ifpc_q;
    idpc_d      = idpc_q;
    idir_d      = idir_q;
    pred_upd    = 1'b0;
    case (state_q)
      FS_RUN: begin
        if (FIN && !WPCIR) begin
          state_d     = FS_DRAIN;
          drain_cnt_d = '0;
          idir_d      = NOP;
        end else if (SMC) begin
          // Refetch the ID instruction; it may have been overwritten.
          ifpc_d = idpc_q;
          idir_d = NOP;
        end else if (SMC2) begin
          idir_d = NOP;
        end else if (WPCIR) begin
          idir_d = idir_q;
        end else if (BRANCH) begin
          ifpc_d   = redirect_tgt;
          idir_d   = NOP;
          pred_upd = !JUMP && !JR;
        end else begin
          idir_d = IMEM_DATA;
          idpc_d = ifpc_q;
          ifpc_d = pred_npc;
        end
      end
      FS_DRAIN: begin
        idir_d = NOP;
        if (drain_cnt_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) state_d = FS_HALT;
        else drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
      end
      FS_HALT: begin
        idir_d = NOP;
      end
      default: begin
        state_d = FS_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= FS_RUN;
      drain_cnt_q <= '0;
      ifpc_q      <= RESET_VECTOR;
      idpc_q      <= RESET_VECTOR;
      idir_q      <= NOP;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      ifpc_q      <= ifpc_d;
      idpc_q      <= idpc_d;
      idir_q      <= idir_d;
      halted_q    <= (state_d == FS_HALT);
    end
  end

  assign IFPC   = ifpc_q;
  assign IDPC   = idpc_q;
  assign IDIR   = idir_q;
  assign HALTED = halted_q;

endmodule
